// File: rtl/fc_weight_sequencer.sv
// fc_weight_sequencer: walks the FC weight memory one row per beat over all passes, with valid/ready flow control.
// Ports:
//   clk, reset               rising-edge clock, synchronous active-high reset
//   start, abort             sweep request (honoured only in IDLE) and sweep cancel (honoured only in FETCH)
//   pe_ready                 PE array accepts the current beat
//   address_fc               weight row address, pass*FC_ROWS + row
//   read_en_MM_fc            weight-memory read enable
//   enable_MM_out_fc         weight-memory output drive enable
//   weight_valid             current beat is valid
//   last_row, last_beat      current beat ends its pass / ends the sweep
//   pass_idx                 current pass number
//   busy, done               high through FETCH / one-cycle completion pulse
//   stall_cycles             FETCH cycles with pe_ready low (present only with FC_WSEQ_PERF_EN)
// Optional feature macro: FC_WSEQ_PERF_EN
module fc_weight_sequencer #(
    parameter int ADDR_WIDTH = 9,
    parameter int FC_ROWS    = 32,
    parameter int NUM_PASSES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  pe_ready,
    output logic [ADDR_WIDTH-1:0] address_fc,
    output logic                  read_en_MM_fc,
    output logic                  enable_MM_out_fc,
    output logic                  weight_valid,
    output logic                  last_row,
    output logic                  last_beat,
    output logic [7:0]            pass_idx,
    output logic                  busy,
    output logic                  done
`ifdef FC_WSEQ_PERF_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);
    localparam int RW = FC_ROWS > 1 ? $clog2(FC_ROWS) : 1;

    if (FC_ROWS < 1 || NUM_PASSES < 1 || NUM_PASSES > 256 ||
        longint'(NUM_PASSES) * longint'(FC_ROWS) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_params
        $error("fc_weight_sequencer: NUM_PASSES*FC_ROWS must fit in 2**ADDR_WIDTH");
    end

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
    state_t state, state_next;
    logic [RW-1:0] row;
    logic accept;

    assign last_row  = state == FETCH && row == RW'(FC_ROWS - 1);
    assign last_beat = last_row && pass_idx == 8'(NUM_PASSES - 1);

    // abort outranks a same-cycle accept, so an aborted beat never advances anything
    always_comb begin
        accept     = weight_valid && pe_ready && !abort;
        state_next = state == IDLE  ? (start ? FETCH : IDLE) :
                     state == FETCH ? (abort ? IDLE : (accept && last_beat) ? DONE : FETCH) :
                                      IDLE;
    end

    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_next;
    end

    // outputs are loaded from the next state so they line up with the state register
    always_ff @(posedge clk) begin
        if (reset) begin
            read_en_MM_fc    <= 1'b0;
            enable_MM_out_fc <= 1'b0;
            weight_valid     <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            read_en_MM_fc    <= state_next == FETCH;
            enable_MM_out_fc <= state_next == FETCH;
            weight_valid     <= state_next == FETCH;
            busy             <= state_next == FETCH;
            done             <= state_next == DONE;
        end
    end

    // the pass stride equals FC_ROWS, so the address simply counts accepted beats
    always_ff @(posedge clk) begin
        if (reset || state_next != FETCH) begin
            row        <= '0;
            pass_idx   <= '0;
            address_fc <= '0;
        end else if (accept) begin
            row        <= last_row ? '0 : row + RW'(1);
            pass_idx   <= last_row ? pass_idx + 8'd1 : pass_idx;
            address_fc <= address_fc + ADDR_WIDTH'(1);
        end
    end

`ifdef FC_WSEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (reset || (state == IDLE && start))
            stall_cycles <= '0;
        else if (state == FETCH && !pe_ready && stall_cycles != '1)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif
endmodule

// File: doc/fc_weight_sequencer.md
Name: fc_weight_sequencer

Overview:
- Controller for the FC-layer weight memory: produces address_fc, read_en_MM_fc and enable_MM_out_fc for one full weight sweep.
- A sweep covers every row of every pass; each beat presents one row of PARALLEL_FC_PE weights to the FC PE array.
- Uses a valid/ready handshake with the PE array, so stalls freeze the address.
- Sits between the layer control FSM (start/done) and the weights memory plus FC PE array.

Parameters:
- ADDR_WIDTH, 9: width of address_fc.
- FC_ROWS, 32: rows per pass; address stride per pass.
- NUM_PASSES, 1: passes per sweep.
- Constraint: NUM_PASSES*FC_ROWS <= 2**ADDR_WIDTH. Elaboration fails if violated.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
- abort  in  1  cancels a sweep in progress.
- pe_ready  in  1  PE array accepts the current beat.
- address_fc  out  ADDR_WIDTH  weight-memory row address.
- read_en_MM_fc  out  1  weight-memory read enable.
- enable_MM_out_fc  out  1  weight-memory output drive enable.
- weight_valid  out  1  current dataMainMemo_fc beat is valid.
- last_row  out  1  current beat is row FC_ROWS-1 of its pass.
- last_beat  out  1  current beat is the final beat of the sweep.
- pass_idx  out  8  current pass number.
- busy  out  1  high in FETCH.
- done  out  1  one-cycle pulse at sweep completion.

Behaviour:
- States: IDLE, FETCH, DONE. All outputs are registered.
- Reset: state IDLE; all outputs 0; row and pass counters 0. Reset mid-sweep returns to IDLE on the next edge with no done pulse.
- Memory read is combinational. Data for address_fc is valid in the same cycle that read_en_MM_fc=1.
- IDLE:
  - All outputs 0.
  - start=1 goes to FETCH next cycle with row=0, pass=0, address_fc=0.
  - start latency: start high at cycle t gives the first weight_valid at t+1.
- FETCH:
  - read_en_MM_fc, enable_MM_out_fc, weight_valid and busy are all 1.
  - address_fc = pass*FC_ROWS + row.
  - A beat is accepted when weight_valid && pe_ready.
  - On accept with row<FC_ROWS-1: row increments.
  - On accept with row=FC_ROWS-1 and pass<NUM_PASSES-1: row goes to 0, pass increments.
  - On accept of the final beat: go to DONE.
  - pe_ready=0 holds all outputs and counters unchanged; the stall is unbounded.
- DONE:
  - done=1 for exactly one cycle; all memory enables 0; then IDLE.
  - A start arriving in DONE is ignored.
- start outside IDLE is ignored and never queued.
- abort:
  - In FETCH it takes priority over accept: go to IDLE next cycle, no done, counters cleared.
  - In IDLE or DONE it is ignored.
- Throughput: one beat per cycle with pe_ready held high. An unstalled sweep takes NUM_PASSES*FC_ROWS FETCH cycles plus 1 DONE cycle.
- last_row and last_beat are combinational decodes of the registered counters, qualified by FETCH.

Optional Feature:
- Macro FC_WSEQ_PERF_EN.
- Defined:
  - Adds output stall_cycles (32 bits): counts FETCH cycles with pe_ready=0.
  - Cleared on reset and on each accepted start; saturates at 0xFFFFFFFF.
  - Holds its value after done or abort.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset for 3 cycles, then release -> all outputs 0; state IDLE; done never pulses.
- Defaults, start pulse, pe_ready=1 -> 32 consecutive beats with address_fc 0..31; last_row and last_beat high at address 31; done pulse 33 cycles after start.
- NUM_PASSES=3, FC_ROWS=4, pe_ready=1 -> addresses 0..11; pass_idx 0,1,2 changes at addresses 4 and 8; last_row high at 3, 7, 11; last_beat only at 11.
- pe_ready=0 for 5 cycles while address_fc=7 -> address_fc, weight_valid and row frozen; sweep resumes at 8. With FC_WSEQ_PERF_EN, stall_cycles=5 at done.
- abort at address_fc=10, with pe_ready=1 in the same cycle -> IDLE next cycle; no done; a following start restarts at address 0.
- start asserted during FETCH and during DONE -> ignored: exactly one sweep and one done pulse; reset asserted mid-sweep -> IDLE, outputs 0 next cycle.
